sd_dat_tx: RTL and testbench

Single-DAT-line block transmitter for the SD host data path. Serializes one block of `BLOCK_BYTES` bytes as a start bit, the data bytes MSB first, the 16-bit CRC and an end bit. Sequences a `crc16` instance (x^16+x^12+x^5+1, zero init), clearing it, feeding it, then freezing and shifting out its result. Sits between the block buffer (byte-read port) and the DAT0 pad driver.

---
 rtl/sd_dat_pkg.sv | 27 ++
 rtl/crc16.sv | 28 ++
 rtl/sd_dat_tx.sv | 153 +++++++++++++++
 tb/tb_sd_dat_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_dat_pkg.sv
// Shared definitions for the SD DAT-line transmitter and the future receiver.
package sd_dat_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_CRC   = 3'd3;
  localparam state_t ST_END   = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

  localparam int          CRC_BITS   = 16;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc16.sv
// Serial CRC-16 generator (x^16+x^12+x^5+1, zero init), one bit per enabled cycle.
module crc16
  import sd_dat_pkg::*;
(
  input  logic                iclk,
  input  logic                irst,
  input  logic                ien,
  input  logic                idata,
  output logic [CRC_BITS-1:0] ocrc
);

  logic [CRC_BITS-1:0] crc_q, crc_d;
  logic                fb;

  always_comb begin
    fb    = crc_q[CRC_BITS-1] ^ idata;
    crc_d = crc_q;
    if (ien) crc_d = {crc_q[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
  end

  always_ff @(posedge iclk) begin
    if (irst) crc_q <= '0;
    else      crc_q <= crc_d;
  end

  assign ocrc = crc_q;

endmodule

// File: rtl/sd_dat_tx.sv
// Single DAT-line block transmitter: start bit, data MSB first, CRC-16, end bit.
// Optional abort input is enabled by defining SD_DAT_TX_ABORT_EN.
//
// state | meaning
// IDLE  | line parked at 1, pad disabled, CRC held clear
// START | start bit on the line, byte 0 captured
// DATA  | data bits on the line, each one fed to the CRC a cycle ahead
// CRC   | latched CRC shifted out MSB first
// END   | end bit on the line, CRC cleared
module sd_dat_tx
  import sd_dat_pkg::*;
#(
  parameter int BLOCK_BYTES = 512
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       istart,
  input  logic [7:0] ibyte,
`ifdef SD_DAT_TX_ABORT_EN
  input  logic       iabort,
`endif
  output logic       odata_req,
  output logic       odat,
  output logic       ooe,
  output logic       obusy,
  output logic       odone
);

  localparam int             BCW       = clog2(8 * BLOCK_BYTES);
  localparam logic [BCW-1:0] LAST      = BCW'(8 * BLOCK_BYTES - 1);
  localparam logic [BCW-1:0] REQ_LIMIT = BCW'(8 * (BLOCK_BYTES - 1));

  state_t              state_q, state_d;
  logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]          byte_q, byte_d;
  logic [CRC_BITS-1:0] crc_sr_q, crc_sr_d;
  logic [3:0]          crc_cnt_q, crc_cnt_d;
  logic                odat_q, odat_d;
  logic                busy_q, busy_d;
  logic                odone_q, odone_d;
  logic                req_c, crc_en, crc_in, crc_rst, abort_c;
  logic [CRC_BITS-1:0] crc_val;

`ifdef SD_DAT_TX_ABORT_EN
  assign abort_c = iabort;
`else
  assign abort_c = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    crc_sr_d  = crc_sr_q;
    crc_cnt_d = crc_cnt_q;
    odone_d   = 1'b0;
    req_c     = 1'b0;
    crc_en    = 1'b0;
    crc_in    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (istart) begin
          req_c     = 1'b1;
          state_d   = ST_START;
          bit_cnt_d = '0;
          crc_cnt_d = '0;
        end
      end
      ST_START: begin
        byte_d  = ibyte;
        state_d = ST_DATA;
        crc_en  = 1'b1;
        crc_in  = ibyte[7];
      end
      ST_DATA: begin
        // Request during bit 1 so the byte arrives for the bit-0 capture.
        if (bit_cnt_q[2:0] == 3'd6 && bit_cnt_q < REQ_LIMIT) req_c = 1'b1;
        if (bit_cnt_q == LAST) begin
          state_d  = ST_CRC;
          crc_sr_d = crc_val;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          byte_d    = (bit_cnt_q[2:0] == 3'd7) ? ibyte : {byte_q[6:0], 1'b0};
          crc_en    = 1'b1;
          crc_in    = byte_d[7];
        end
      end
      ST_CRC: begin
        crc_sr_d = {crc_sr_q[CRC_BITS-2:0], 1'b0};
        if (crc_cnt_q == 4'd15) begin
          state_d = ST_END;
          odone_d = 1'b1;
        end else begin
          crc_cnt_d = crc_cnt_q + 4'd1;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort_c && (state_q == ST_START || state_q == ST_DATA || state_q == ST_CRC)) begin
      state_d = ST_END;
      odone_d = 1'b0;
    end

    case (state_d)
      ST_START: odat_d = START_BIT;
      ST_DATA:  odat_d = byte_d[7];
      ST_CRC:   odat_d = crc_sr_d[CRC_BITS-1];
      default:  odat_d = END_BIT;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      byte_q    <= '0;
      crc_sr_q  <= '0;
      crc_cnt_q <= '0;
      odat_q    <= END_BIT;
      busy_q    <= 1'b0;
      odone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      crc_sr_q  <= crc_sr_d;
      crc_cnt_q <= crc_cnt_d;
      odat_q    <= odat_d;
      busy_q    <= busy_d;
      odone_q   <= odone_d;
    end
  end

  assign crc_rst = irst | (state_q == ST_IDLE) | (state_q == ST_END);

  crc16 u_crc16 (
    .iclk  (iclk),
    .irst  (crc_rst),
    .ien   (crc_en),
    .idata (crc_in),
    .ocrc  (crc_val)
  );

  assign odata_req = req_c & ~irst;
  assign odat      = odat_q;
  assign ooe       = busy_q;
  assign obusy     = busy_q;
  assign odone     = odone_q;

endmodule

// File: tb/tb_sd_dat_tx.sv
// Directed bench for sd_dat_tx: three block sizes (512, 9, 1) on one clock.
module tb_sd_dat_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic abort_v = 1'b0;
  logic clr = 1'b0;
  logic a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
  logic [7:0] a_ibyte, b_ibyte, c_ibyte;
  logic a_req, a_odat, a_ooe, a_busy, a_done;
  logic b_req, b_odat, b_ooe, b_busy, b_done;
  logic c_req, c_odat, c_ooe, c_busy, c_done;

  int n_vec = 0;
  int n_bad = 0;
  int sel = 0;
  int b_cnt = 0;

  logic [7:0] b_msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  assign a_ibyte = 8'hFF;
  assign c_ibyte = 8'h00;
  assign b_ibyte = (b_cnt > 0 && b_cnt <= 9) ? b_msg[b_cnt-1] : 8'h00;

  always @(posedge clk) begin
    if (clr)        b_cnt <= 0;
    else if (b_req) b_cnt <= b_cnt + 1;
  end

  sd_dat_tx #(.BLOCK_BYTES(512)) u_a (
    .iclk(clk), .irst(rst), .istart(a_start), .ibyte(a_ibyte),
`ifdef SD_DAT_TX_ABORT_EN
    .iabort(abort_v),
`endif
    .odata_req(a_req), .odat(a_odat), .ooe(a_ooe), .obusy(a_busy), .odone(a_done));

  sd_dat_tx #(.BLOCK_BYTES(9)) u_b (
    .iclk(clk), .irst(rst), .istart(b_start), .ibyte(b_ibyte),
`ifdef SD_DAT_TX_ABORT_EN
    .iabort(abort_v),
`endif
    .odata_req(b_req), .odat(b_odat), .ooe(b_ooe), .obusy(b_busy), .odone(b_done));

  sd_dat_tx #(.BLOCK_BYTES(1)) u_c (
    .iclk(clk), .irst(rst), .istart(c_start), .ibyte(c_ibyte),
`ifdef SD_DAT_TX_ABORT_EN
    .iabort(abort_v),
`endif
    .odata_req(c_req), .odat(c_odat), .ooe(c_ooe), .obusy(c_busy), .odone(c_done));

  logic m_req, m_odat, m_ooe, m_busy, m_done;
  always_comb begin
    m_req = a_req; m_odat = a_odat; m_ooe = a_ooe; m_busy = a_busy; m_done = a_done;
    case (sel)
      1: begin m_req = b_req; m_odat = b_odat; m_ooe = b_ooe; m_busy = b_busy; m_done = b_done; end
      2: begin m_req = c_req; m_odat = c_odat; m_ooe = c_ooe; m_busy = c_busy; m_done = c_done; end
      default: ;
    endcase
  end

  // per-cycle log of the selected DUT; index = cycle number, 0 = istart cycle
  bit q_odat[$], q_ooe[$], q_busy[$], q_done[$], q_req[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_q(input int kind, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (kind)
        0: n += int'(q_odat[i]);
        1: n += int'(q_ooe[i]);
        2: n += int'(q_busy[i]);
        3: n += int'(q_done[i]);
        default: n += int'(q_req[i]);
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] bits_at(input int base, input int len);
    logic [31:0] v = '0;
    for (int i = 0; i < len; i++) v = {v[30:0], q_odat[base+i]};
    return v;
  endfunction

  task automatic set_start(input int s, input logic v);
    a_start = (s == 0) && v;
    b_start = (s == 1) && v;
    c_start = (s == 2) && v;
  endtask

  task automatic run(input int s, input int ncyc, input logic hold, input int rst_at, input int abort_at);
    sel = s;
    q_odat.delete(); q_ooe.delete(); q_busy.delete(); q_done.delete(); q_req.delete();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    set_start(s, 1'b1);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      q_odat.push_back(m_odat); q_ooe.push_back(m_ooe); q_busy.push_back(m_busy);
      q_done.push_back(m_done); q_req.push_back(m_req);
      @(posedge clk); #1;
      set_start(s, hold);
      rst     = (c + 1 == rst_at);
      abort_v = (c + 1 == abort_at);
    end
    set_start(s, 1'b0);
    rst = 1'b0;
    abort_v = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_odat", a_odat, 1);
    chk("rst_ooe", a_ooe, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_req", a_req, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 512 bytes of 0xFF: N=512, end bit at 4114
    run(0, 4116, 1'b0, -1, -1);
    chk("a_req0", q_req[0], 1);
    chk("a_start_bit", q_odat[1], 0);
    chk("a_ones", count_q(0, 2, 4097), 4096);
    chk("a_crc", bits_at(4098, 16), 32'h7FA1);
    chk("a_end_bit", q_odat[4114], 1);
    chk("a_done_at_end", q_done[4114], 1);
    chk("a_done_count", count_q(3, 0, 4115), 1);
    chk("a_ooe_count", count_q(1, 0, 4115), 4114);
    chk("a_busy_count", count_q(2, 0, 4115), 4114);
    chk("a_ooe_idle", q_ooe[4115], 0);
    chk("a_req_count", count_q(4, 0, 4115), 512);

    // "123456789": N=9, CRC at 74..89, end at 90
    do_reset();
    run(1, 92, 1'b0, -1, -1);
    chk("b_req_count", count_q(4, 0, 91), 9);
    for (int n = 0; n < 9; n++) chk($sformatf("b_req_at_%0d", 8 * n), q_req[8*n], 1);
    chk("b_byte0", bits_at(2, 8), 32'h31);
    chk("b_byte8", bits_at(66, 8), 32'h39);
    chk("b_crc", bits_at(74, 16), 32'h31C3);
    chk("b_done", q_done[90], 1);

    // single 0x00 byte: 26 cycles of ooe, only the end bit high
    do_reset();
    run(2, 28, 1'b0, -1, -1);
    chk("c_seq", bits_at(1, 26), 32'h1);
    chk("c_ooe_count", count_q(1, 0, 27), 26);
    chk("c_ooe_idle", q_ooe[27], 0);

    // istart held: END cycle 26 ignores it, IDLE 27 accepts, start bit 28
    do_reset();
    run(2, 30, 1'b1, -1, -1);
    chk("h_done", q_done[26], 1);
    chk("h_no_req_end", q_req[26], 0);
    chk("h_req_idle", q_req[27], 1);
    chk("h_ooe_idle", q_ooe[27], 0);
    chk("h_start2", q_odat[28], 0);
    chk("h_ooe2", q_ooe[28], 1);

    // reset mid-transfer, then a clean 0xFF block
    do_reset();
    run(0, 102, 1'b0, 100, -1);
    chk("r_odat", q_odat[101], 1);
    chk("r_ooe", q_ooe[101], 0);
    chk("r_busy", q_busy[101], 0);
    chk("r_done", count_q(3, 0, 101), 0);
    run(0, 4116, 1'b0, -1, -1);
    chk("r_crc", bits_at(4098, 16), 32'h7FA1);
    chk("r_done_end", q_done[4114], 1);

`ifdef SD_DAT_TX_ABORT_EN
    do_reset();
    run(1, 55, 1'b0, -1, 50);
    chk("ab_end_bit", q_odat[51], 1);
    chk("ab_ooe_end", q_ooe[51], 1);
    chk("ab_ooe_idle", q_ooe[52], 0);
    chk("ab_busy_idle", q_busy[52], 0);
    chk("ab_done", count_q(3, 0, 54), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
